// File: rtl/potential_decay_scheduler.sv
`default_nettype none
// potential_decay_scheduler: per-time-step sequencer that leaks each stored membrane
// potential, drives the combinational adder, and writes back potential and spike.
module potential_decay_scheduler #(
    parameter int NEURONS = 4,
    parameter int IDX_W   = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  start,
    input  logic [2:0]            decay_shift,
    input  logic [32*NEURONS-1:0] weight_in,
    input  logic [31:0]           final_potential1,
    input  logic                  spike1,
    output logic [31:0]           decayed_potential1,
    output logic [31:0]           input_weight1,
    output logic                  set_adder1,
    output logic                  clear_adder1,
    output logic [NEURONS-1:0]    spike_vec,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [31:0]           rd_potential,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_CLEAR, S_DECAY, S_APPLY, S_CAPTURE, S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [2:0]         k_q;
    logic [31:0]        store_q  [NEURONS];
    logic [31:0]        weight_q [NEURONS];
    logic [31:0]        dec_q;
    logic [31:0]        win_q;
    logic               set_q;
    logic               clr_q;
    logic               busy_q;
    logic               done_q;
    logic [NEURONS-1:0] spike_q;
    logic [31:0]        leak_d;

    // Power-of-two leak applied directly on the exponent field; underflow flushes to +0.
    function automatic logic [31:0] leak(input logic [31:0] v, input logic [2:0] k);
        logic [7:0] e;
        e = v[30:23];
        if (e == 8'hFF)
            leak = v;
        else if (e == 8'h00)
            leak = 32'h0000_0000;
        else if (k == 3'd0)
            leak = v;
        else if (e <= {5'd0, k})
            leak = 32'h0000_0000;
        else
            leak = {v[31], e - {5'd0, k}, v[22:0]};
    endfunction

    // Neuron whose operands are loaded on this edge: 0 from CLEAR, idx+1 from CAPTURE.
    always_comb begin
        idx_d  = (state_q == S_CAPTURE) ? idx_q + IDX_W'(1) : idx_q;
        leak_d = leak(store_q[idx_d], k_q);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_INIT;
            idx_q   <= '0;
            k_q     <= '0;
            dec_q   <= '0;
            win_q   <= '0;
            set_q   <= 1'b1;
            clr_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            spike_q <= '0;
            for (int i = 0; i < NEURONS; i++) begin
                store_q[i]  <= '0;
                weight_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_INIT: begin
                    set_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NEURONS; i++)
                            weight_q[i] <= weight_in[32*i +: 32];
                        k_q     <= decay_shift;
                        idx_q   <= '0;
                        clr_q   <= 1'b1;
                        spike_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    clr_q   <= 1'b0;
                    dec_q   <= leak_d;
                    win_q   <= weight_q[idx_d];
                    state_q <= S_DECAY;
                end
                S_DECAY: state_q <= S_APPLY;
                S_APPLY: state_q <= S_CAPTURE;
                S_CAPTURE: begin
                    store_q[idx_q] <= final_potential1;
                    spike_q[idx_q] <= spike1;
                    if (idx_q == LAST_IDX) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_d;
                        dec_q   <= leak_d;
                        win_q   <= weight_q[idx_d];
                        state_q <= S_DECAY;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign decayed_potential1 = dec_q;
    assign input_weight1      = win_q;
    assign set_adder1         = set_q;
    assign clear_adder1       = clr_q;
    assign spike_vec          = spike_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign rd_potential       = (int'(rd_idx) < NEURONS) ? store_q[rd_idx] : 32'h0000_0000;

endmodule
`default_nettype wire

// File: doc/potential_decay_scheduler.md
# potential_decay_scheduler

Time-step sequencer and membrane-potential store that sits directly upstream of `potential_adder1` in the 4-neuron accelerator. On each time step it walks the neurons one at a time:
- reads the stored potential and applies an FP32 power-of-two leak;
- drives `decayed_potential1`/`input_weight1` into the combinational adder;
- captures the returned `final_potential1`/`spike1`, writes the potential back and records the spike.

It also generates the adder's `set_adder1`/`clear_adder1` controls.

## Interface
Parameters:
- `NEURONS`, 4, number of neurons served (≥1).
- `IDX_W`, 2, index width, equal to clog2(`NEURONS`).

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse that begins a time step; ignored unless in IDLE.
- `decay_shift` in 3: leak exponent k (potential × 2^-k), sampled at `start`. 0 means no leak.
- `weight_in` in 32·`NEURONS`: FP32 accumulated input weight per neuron. Neuron i occupies bits [32i+31:32i]. Sampled at `start`.
- `final_potential1` in 32: from adder.
- `spike1` in 1: from adder.
- `decayed_potential1` out 32: to adder.
- `input_weight1` out 32: to adder.
- `set_adder1` out 1: to adder.
- `clear_adder1` out 1: to adder.
- `spike_vec` out `NEURONS`: spikes of the last completed time step.
- `rd_idx` in `IDX_W`: potential readout index.
- `rd_potential` out 32: combinational read of potential store[`rd_idx`].
- `busy` out 1: high whenever the FSM is not in IDLE.
- `done` out 1: one-cycle pulse at time-step completion.

## Operation
State machine: INIT → IDLE → CLEAR → (DECAY → APPLY → CAPTURE) × `NEURONS` → DONE → IDLE.

- **Reset (asynchronous):**
  - Potential store cleared to 32'h00000000; `spike_vec`=0.
  - Outputs: `decayed_potential1`=0, `input_weight1`=0, `clear_adder1`=0, `done`=0.
  - `set_adder1`=1, `busy`=1; state INIT.
- **INIT:** one cycle with `set_adder1`=1, then IDLE. `set_adder1` is 0 in every other state.
- **IDLE:** `busy`=0. On `start`=1, latch `weight_in` into weight registers and `decay_shift` into k, set idx=0, go to CLEAR.
- **CLEAR:** `clear_adder1`=1 for exactly this cycle; `spike_vec` cleared to 0.
- **DECAY:** register `decayed_potential1` = leak(store[idx]) and `input_weight1` = weight[idx].
- **APPLY:** outputs held stable for one settle cycle.
- **CAPTURE:**
  - store[idx] ← `final_potential1`; `spike_vec`[idx] ← `spike1`.
  - If idx = `NEURONS`-1, go to DONE; else idx+1 and go to DECAY.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Leak arithmetic** on input v = {s, e[7:0], m[22:0]}:
  - e = 255 (Inf/NaN): pass v unchanged.
  - e = 0 (zero/denormal): output 32'h00000000.
  - k = 0: v unchanged.
  - e ≤ k: flush to 32'h00000000; the sign is not preserved.
  - otherwise: {s, e−k, m}.
- `decayed_potential1`/`input_weight1` hold their last values outside DECAY/APPLY/CAPTURE.

## Timing
- `start` sampled at edge T0:
  - CLEAR occupies cycle T0+1.
  - Neuron i is in DECAY/APPLY/CAPTURE during cycles T0+2+3i, +3+3i, +4+3i; the CAPTURE writeback lands on the edge that ends cycle T0+4+3i.
  - DONE (`done`=1) is in cycle T0+2+3·`NEURONS` (cycle T0+14 for N=4).
  - IDLE resumes in the following cycle, in which `start` is accepted again.
- `start` while `busy`=1: ignored, no queuing. `start` held high across DONE→IDLE begins a new step.
- `spike_vec` updates bit by bit during the step; it is valid for the whole step when `done` pulses and holds until the next CLEAR.
- `rd_potential` reflects a write in the cycle after the writeback edge.
- `RESET` mid-step: the step is aborted immediately, all state returns to reset values, no `done` is produced, and the FSM re-enters INIT.

## Test plan
The bench uses a behavioural adder stub: sum = a+b; `spike1` = (sum > 40.0); final = sum−40.0 on spike, else sum. `clear_adder1` forces `spike1`=0.

- **Reset/INIT:** `RESET` pulse → all outputs at reset values; one cycle later `set_adder1`=1 then 0; `busy` falls after INIT.
- **First step:** k=1, weight[0]=30.0 (32'h41F00000), others 0, `start` → `decayed_potential1`=0 for every neuron; store[0]=32'h41F00000; `spike_vec`=0; `done` exactly 14 cycles after `start`.
- **Second step, same weights:** → neuron 0 decayed 15.0 (32'h41700000), sum 45.0; `spike_vec`[0]=1; store[0]=5.0 (32'h40A00000).
- **Leak edges:**
  - k=7, potential 1.0 (32'h3F800000, e=127) → 32'h3C000000.
  - potential with e=3, k=3 → 32'h00000000.
  - 32'h7F800000 → passes unchanged.
  - k=0 → unchanged.
- **Busy:** `start` re-asserted in cycle T0+5 → ignored, `done` still at T0+14 only. `start` held high through DONE → a new step begins the cycle after DONE.
- **Mid-step reset:** `RESET` in cycle T0+7 → store all zero, no `done`, `set_adder1` reasserted after release, next `start` completes normally.
